// File: rtl/rest_payout_ctrl.sv
// Change-payout sequencer: greedy 5/2/1 coin ejection with fixed inter-coin spacing,
// per-denomination inventory counters with saturating refill, and shortfall reporting.
module rest_payout_ctrl #(
  parameter int AW       = 4,
  parameter int CW       = 6,
  parameter int GAP      = 3,
  parameter int INIT_CNT = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic [AW-1:0] req_amount_i,
  output logic          req_ready_o,
  input  logic          refill5_i,
  input  logic          refill2_i,
  input  logic          refill1_i,
  output logic          ej5_o,
  output logic          ej2_o,
  output logic          ej1_o,
  output logic          done_o,
  output logic          short_o,
  output logic [AW-1:0] owed_o,
  output logic [CW-1:0] cnt5_o,
  output logic [CW-1:0] cnt2_o,
  output logic [CW-1:0] cnt1_o
);

  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] owed_q, owed_d;
  logic [CW-1:0] cnt5_q, cnt5_d, cnt2_q, cnt2_d, cnt1_q, cnt1_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    ej_q, ej_d;
  logic          done_q, done_d, short_q, short_d, ready_q, ready_d;
  logic [AW-1:0] coin_val;

  // Refill and eject in the same cycle cancel; refill saturates at all-ones.
  function automatic logic [CW-1:0] inv_next(input logic [CW-1:0] c, input logic add,
                                             input logic sub);
    logic [CW-1:0] r;
    r = c;
    if (add && !sub) begin
      if (c != {CW{1'b1}}) r = c + CW'(1);
      else                 r = c;
    end else if (sub && !add) begin
      r = c - CW'(1);
    end else begin
      r = c;
    end
    return r;
  endfunction

  always_comb begin
    if (ej_q[2])      coin_val = AW'(5);
    else if (ej_q[1]) coin_val = AW'(2);
    else              coin_val = AW'(1);
  end

  // Next-state logic; ej/done/ready are registered from the next state so they align with it.
  always_comb begin
    state_d = state_q;
    owed_d  = owed_q;
    short_d = short_q;
    gap_d   = gap_q;
    ej_d    = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          owed_d  = req_amount_i;
          short_d = 1'b0;
          if (req_amount_i == '0) state_d = S_DONE;
          else                    state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (owed_q >= AW'(5) && cnt5_q != '0)      ej_d = 3'b100;
        else if (owed_q >= AW'(2) && cnt2_q != '0) ej_d = 3'b010;
        else if (cnt1_q != '0)                     ej_d = 3'b001;
        else                                       ej_d = 3'b000;
        if (ej_d != 3'b000) begin
          state_d = S_PULSE;
        end else begin
          state_d = S_DONE;
          short_d = 1'b1;
        end
      end
      S_PULSE: begin
        owed_d = owed_q - coin_val;
        gap_d  = '0;
        if (GAP > 0)            state_d = S_GAP;
        else if (owed_d == '0)  state_d = S_DONE;
        else                    state_d = S_SELECT;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          if (owed_q == '0) state_d = S_DONE;
          else              state_d = S_SELECT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    cnt5_d  = inv_next(cnt5_q, refill5_i, ej_q[2]);
    cnt2_d  = inv_next(cnt2_q, refill2_i, ej_q[1]);
    cnt1_d  = inv_next(cnt1_q, refill1_i, ej_q[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owed_q  <= '0;
      short_q <= 1'b0;
      gap_q   <= '0;
      ej_q    <= 3'b000;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      cnt5_q  <= CW'(INIT_CNT);
      cnt2_q  <= CW'(INIT_CNT);
      cnt1_q  <= CW'(INIT_CNT);
    end else begin
      state_q <= state_d;
      owed_q  <= owed_d;
      short_q <= short_d;
      gap_q   <= gap_d;
      ej_q    <= ej_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      cnt5_q  <= cnt5_d;
      cnt2_q  <= cnt2_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign req_ready_o = ready_q;
  assign ej5_o       = ej_q[2];
  assign ej2_o       = ej_q[1];
  assign ej1_o       = ej_q[0];
  assign done_o      = done_q;
  assign short_o     = short_q;
  assign owed_o      = owed_q;
  assign cnt5_o      = cnt5_q;
  assign cnt2_o      = cnt2_q;
  assign cnt1_o      = cnt1_q;

endmodule

// File: tb/tb_rest_payout_ctrl.sv
// Bench for rest_payout_ctrl: directed scenarios plus randomized payouts/refills against
// a greedy reference model that predicts coin order, pulse timing and inventory.
module tb_rest_payout_ctrl;
  localparam int AW = 4, CW = 6, GAP = 3, INIT = 10, STEP = 2 + GAP;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0, rst;
  logic          req_valid_i, refill5_i, refill2_i, refill1_i;
  logic [AW-1:0] req_amount_i;
  logic          req_ready_o, ej5_o, ej2_o, ej1_o, done_o, short_o;
  logic [AW-1:0] owed_o;
  logic [CW-1:0] cnt5_o, cnt2_o, cnt1_o;

  int checks = 0, errors = 0;
  int m[3];  // model inventory: [0]=5s, [1]=2s, [2]=1s

  rest_payout_ctrl #(.AW(AW), .CW(CW), .GAP(GAP), .INIT_CNT(INIT)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_amount_i(req_amount_i),
    .req_ready_o(req_ready_o), .refill5_i(refill5_i), .refill2_i(refill2_i),
    .refill1_i(refill1_i), .ej5_o(ej5_o), .ej2_o(ej2_o), .ej1_o(ej1_o), .done_o(done_o),
    .short_o(short_o), .owed_o(owed_o), .cnt5_o(cnt5_o), .cnt2_o(cnt2_o), .cnt1_o(cnt1_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt5"}, cnt5_o, m[0]);
    chk({tag, "_cnt2"}, cnt2_o, m[1]);
    chk({tag, "_cnt1"}, cnt1_o, m[2]);
  endtask

  // Issue one request and check every cycle until done against the greedy model.
  task automatic do_payout(input int amt, input bit hold, input int next_amt, input bit rf5_p0);
    int c[3];
    int coins[$];
    int owed, k, done_cyc, exp_ej;
    bit sh;
    c = m; owed = amt; sh = 1'b0;
    while (owed > 0) begin
      if (owed >= 5 && c[0] > 0)      begin coins.push_back(0); c[0]--; owed -= 5; end
      else if (owed >= 2 && c[1] > 0) begin coins.push_back(1); c[1]--; owed -= 2; end
      else if (c[2] > 0)              begin coins.push_back(2); c[2]--; owed -= 1; end
      else begin sh = 1'b1; break; end
    end
    k = coins.size();
    done_cyc = (amt == 0) ? 1 : (sh ? 2 + k * STEP : 1 + k * STEP);
    req_valid_i = 1'b1;
    req_amount_i = AW'(amt);
    @(negedge clk);
    chk("ready_idle", req_ready_o, 1);
    next_cycle();
    if (hold) req_amount_i = AW'(next_amt);
    else      req_valid_i = 1'b0;
    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      exp_ej = 0;
      if (cyc >= 2 && (cyc - 2) % STEP == 0 && (cyc - 2) / STEP < k)
        exp_ej = 4 >> coins[(cyc - 2) / STEP];
      refill5_i = rf5_p0 && (cyc == 2);
      @(negedge clk);
      chk("ej", {ej5_o, ej2_o, ej1_o}, exp_ej);
      chk("done", done_o, (cyc == done_cyc));
      chk("ready_busy", req_ready_o, 0);
      if (cyc == done_cyc) begin
        if (rf5_p0) c[0] = (c[0] + 1 > MAXC) ? MAXC : c[0] + 1;
        m = c;
        chk("short", short_o, sh);
        chk("owed", owed_o, owed);
        chk_counts("pay");
      end
      next_cycle();
    end
    refill5_i = 1'b0;
  endtask

  task automatic do_refill(input logic [2:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      {refill5_i, refill2_i, refill1_i} = mask;
      @(negedge clk);
      chk("idle_ej", {ej5_o, ej2_o, ej1_o}, 0);
      chk("idle_ready", req_ready_o, 1);
      next_cycle();
      for (int j = 0; j < 3; j++)
        if (mask[2-j]) m[j] = (m[j] + 1 > MAXC) ? MAXC : m[j] + 1;
    end
    {refill5_i, refill2_i, refill1_i} = 3'b000;
    chk_counts("refill");
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ej"}, {ej5_o, ej2_o, ej1_o}, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_short"}, short_o, 0);
    chk({tag, "_owed"}, owed_o, 0);
    chk({tag, "_ready"}, req_ready_o, 1);
    m = '{INIT, INIT, INIT};
    chk_counts(tag);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_amount_i = '0;
    refill5_i = 1'b0; refill2_i = 1'b0; refill1_i = 1'b0;
    #12;
    chk_reset_state("reset");
    #5 rst = 1'b0;
    next_cycle();

    // Greedy 8 = 5+2+1, then zero amount, then held valid with changing amount.
    do_payout(8, 1'b0, 0, 1'b0);
    chk("t1_cnt5", cnt5_o, 9);
    chk("t1_cnt1", cnt1_o, 9);
    do_payout(0, 1'b0, 0, 1'b0);
    do_payout(3, 1'b1, 1, 1'b0);
    do_payout(1, 1'b0, 0, 1'b0);

    // Reset during the first gap of a payout of 8.
    req_valid_i = 1'b1; req_amount_i = AW'(8);
    next_cycle();
    req_valid_i = 1'b0;
    next_cycle();
    next_cycle();
    #2 rst = 1'b1;
    #1 chk_reset_state("midrst");
    #3 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_ej", {ej5_o, ej2_o, ej1_o}, 0);
      next_cycle();
    end

    // Refill coinciding with the eject of the same denomination.
    do_payout(5, 1'b0, 0, 1'b1);
    chk("t4_cnt5", cnt5_o, INIT);

    // Empty the 1s, then 3 pays a 2 and stops short with 1 owed.
    for (int i = 0; i < INIT; i++) do_payout(1, 1'b0, 0, 1'b0);
    do_payout(3, 1'b0, 0, 1'b0);
    chk("t3_short", short_o, 1);
    chk("t3_owed", owed_o, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0)
        do_refill(3'($urandom_range(1, 7)), $urandom_range(1, 4));
      else
        do_payout($urandom_range(0, 15), 1'b0, 0, 1'b0);
    end

    do_refill(3'b111, 70);
    chk("sat_cnt5", cnt5_o, MAXC);
    do_payout(15, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
